// File: rtl/prefix_carry_pipe_8b.sv
// Kogge-Stone carry network for the 8-bit adder. Takes propagate/generate
// vectors (bit 0 holds carry-in) through four prefix levels (span 1,2,4,8).
// Register slices after any level are chosen by STAGE_MASK. The stage
// produces sum, carry-out and signed overflow behind a valid/ready handshake.
// Latency is 1 + popcount(STAGE_MASK). The input capture register is always
// present.

// One prefix level: bit i absorbs bit i-SPAN, and lower bits pass through.
module ks_level #(
  parameter int SPAN = 1
) (
  input  logic [8:0] g_i,
  input  logic [8:0] p_i,
  output logic [8:0] g_o,
  output logic [8:0] p_o
);
  for (genvar i = 0; i < 9; i++) begin : g_bit
    if (i >= SPAN) begin : g_op
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      assign p_o[i] = p_i[i] & p_i[i-SPAN];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end
endmodule

module prefix_carry_pipe_8b #(
  parameter logic [3:0] STAGE_MASK = 4'b0101
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [8:0] prop_i,
  input  logic [8:0] gen_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] sum_o,
  output logic       carry_o,
  output logic       overflow_o
);
  // g/p are the running group terms.
  // pc is the original propagate copy used for the final sum XOR.
  typedef struct packed {
    logic [8:0] g;
    logic [8:0] p;
    logic [7:0] pc;
  } slot_t;

  // Occupancy per point. Points without a register never count as a hole.
  // A register therefore advances when any point at or after it is empty,
  // or when the consumer takes the result.
  logic [4:0] full;

  assign ready_o = ready_i | ~&full;

  // Point 0 is the capture register.
  // Point n (n>=1) is the output of prefix level n-1, registered or not.
  for (genvar n = 0; n < 5; n++) begin : g_pt
    slot_t d;
    logic  v;

    if (n == 0) begin : g_cap
      slot_t q;
      logic  vq;
      // Capture input vectors; data is touched only when a valid word is taken.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vq <= 1'b0;
          q  <= '0;
        end else if (ready_o) begin
          vq <= valid_i;
          if (valid_i) q <= '{g: gen_i, p: prop_i, pc: prop_i[8:1]};
        end
      end
      assign d       = q;
      assign v       = vq;
      assign full[0] = vq;
    end else begin : g_lvl
      logic [8:0] cg, cp;
      slot_t      c;
      ks_level #(.SPAN(1 << (n - 1))) u_lvl (
        .g_i(g_pt[n-1].d.g),
        .p_i(g_pt[n-1].d.p),
        .g_o(cg),
        .p_o(cp)
      );
      assign c = '{g: cg, p: cp, pc: g_pt[n-1].d.pc};

      if (STAGE_MASK[n-1]) begin : g_reg
        slot_t q;
        logic  vq;
        logic  adv;
        assign adv = ready_i | ~&full[4:n];
        // Pipeline slice. An empty predecessor loads a bubble and data is held.
        always_ff @(posedge clk_i) begin
          if (!rst_ni) begin
            vq <= 1'b0;
            q  <= '0;
          end else if (adv) begin
            vq <= g_pt[n-1].v;
            if (g_pt[n-1].v) q <= c;
          end
        end
        assign d       = q;
        assign v       = vq;
        assign full[n] = vq;
      end else begin : g_thru
        assign d       = c;
        assign v       = g_pt[n-1].v;
        assign full[n] = 1'b1;
      end
    end
  end

  // g[j] is now the carry into bit j (bit 0 = carry-in).
  assign valid_o    = g_pt[4].v;
  assign sum_o      = g_pt[4].d.pc ^ g_pt[4].d.g[7:0];
  assign carry_o    = g_pt[4].d.g[8];
  assign overflow_o = g_pt[4].d.g[7] ^ g_pt[4].d.g[8];

  // The group-propagate terms are not needed once the last level has run.
  logic unused_p;
  assign unused_p = ^g_pt[4].d.p;
endmodule

// File: tb/tb_prefix_carry_pipe_8b.sv
// Scoreboard bench for prefix_carry_pipe_8b. It runs three instances with
// STAGE_MASK 0101, 0000 and 1111 in parallel. Each instance has its own
// driver, expected-result queue and monitor.
module tb_prefix_carry_pipe_8b;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  typedef struct {
    logic [9:0] res;   // {overflow, carry, sum}
    int         t_in;  // edge on which the input was accepted
    bit         lat;   // check latency for this entry
  } exp_t;

  localparam logic [3:0] MASKS [3] = '{4'b0101, 4'b0000, 4'b1111};

  // Directed table entries: {a, b, cin, expected {ovf, carry, sum}}.
  localparam logic [26:0] DIR [7] = '{
    {8'hFF, 8'h01, 1'b0, 10'h100},
    {8'h7F, 8'h01, 1'b0, 10'h280},
    {8'h00, 8'h00, 1'b1, 10'h001},
    {8'h80, 8'h80, 1'b0, 10'h300},
    {8'h55, 8'hAA, 1'b1, 10'h100},
    {8'h40, 8'h3F, 1'b1, 10'h280},
    {8'hFF, 8'hFF, 1'b1, 10'h1FF}
  };

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    return {(a[7] == b[7]) && (s[7] != a[7]), s[8], s[7:0]};
  endfunction

  task automatic check(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL mask%0d %s: got %h, required %h", k, nm, act, exp);
    end
  endtask

  task automatic note_fail(input int k, input string nm);
    checks++;
    errors++;
    $display("FAIL mask%0d %s", k, nm);
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam logic [3:0] M = MASKS[k];
    localparam int L = 1 + int'(M[0]) + int'(M[1]) + int'(M[2]) + int'(M[3]);

    logic       rst_n, vin, rdy, rout, vout, carry, ovf;
    logic [8:0] prop, gen;
    logic [7:0] sum;
    exp_t       exp_q[$];

    prefix_carry_pipe_8b #(.STAGE_MASK(M)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vin), .ready_o(rout),
      .prop_i(prop), .gen_i(gen), .valid_o(vout), .ready_i(rdy),
      .sum_o(sum), .carry_o(carry), .overflow_o(ovf)
    );

    // Called at a negedge. Holds the word until accepted and returns at the next negedge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [9:0] exp, input bit lat);
      bit done = 0;
      int n = 0;
      prop = {a ^ b, 1'b0};
      gen  = {a & b, cin};
      vin  = 1'b1;
      while (!done) begin
        #4;
        if (rout) begin
          exp_q.push_back('{res: exp, t_in: cyc + 1, lat: lat});
          done = 1;
        end else if (++n > 50) begin
          note_fail(k, "send_timeout");
          done = 1;
        end
        @(negedge clk);
      end
      vin = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check(k, "drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : drv
      logic [7:0]  a, b;
      logic        c;
      logic [26:0] t;
      int          t0;
      rst_n = 1'b0; vin = 1'b0; rdy = 1'b0; prop = '0; gen = '0;
      repeat (2) @(negedge clk);
      #4;
      check(k, "reset_state", 32'({vout, rout, ovf, carry, sum}), 32'({1'b0, 1'b1, 10'h000}));
      @(negedge clk);
      rst_n = 1'b1;
      rdy   = 1'b1;

      // Isolated directed words: result plus latency.
      for (int i = 0; i < 7; i++) begin
        t = DIR[i];
        send(t[26:19], t[18:11], t[10], t[9:0], 1'b1);
        drain();
      end

      // Back-to-back stream: one word accepted per cycle.
      t0 = cyc;
      for (int i = 0; i < 256; i++) begin
        a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
        send(a, b, c, model(a, b, c), 1'b0);
      end
      check(k, "throughput_cycles", 32'(cyc - t0), 32'd256);
      drain();

      // Fill with the consumer stalled, hold for five cycles, then release.
      rdy = 1'b0;
      for (int i = 0; i < L; i++) begin
        a = 8'(8'h21 * (i + 1)); b = 8'(8'h5B + i);
        send(a, b, 1'b0, model(a, b, 1'b0), 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
        #4;
        check(k, "stall_ready", 32'(rout), 32'd0);
        check(k, "stall_valid", 32'(vout), 32'd1);
        check(k, "stall_depth", 32'(exp_q.size()), 32'(L));
        if (exp_q.size() > 0)
          check(k, "stall_hold", 32'({ovf, carry, sum}), 32'(exp_q[0].res));
        @(negedge clk);
      end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
        a = 8'(8'hC3 + i); b = 8'(8'h3D - i);
        send(a, b, 1'(i), model(a, b, 1'(i)), 1'b0);
      end
      drain();

      // Reset with words in flight: they must vanish without output.
      send(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0), 1'b0);
      send(8'h56, 8'h78, 1'b1, model(8'h56, 8'h78, 1'b1), 1'b0);
      rst_n = 1'b0;
      rdy   = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rdy   = 1'b1;
      #4;
      check(k, "rst_valid", 32'(vout), 32'd0);
      check(k, "rst_data", 32'({ovf, carry, sum}), 32'd0);
      check(k, "rst_ready", 32'(rout), 32'd1);
      @(negedge clk);
      send(8'h0F, 8'h01, 1'b0, 10'h010, 1'b1);
      drain();
      mark_done();
    end

    // Pops the scoreboard on every output transfer, just before the edge.
    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        #4;
        if (rst_n === 1'b1 && vout === 1'b1 && rdy === 1'b1) begin
          if (exp_q.size() == 0) begin
            note_fail(k, "unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check(k, "result", 32'({ovf, carry, sum}), 32'(e.res));
            if (e.lat) check(k, "latency", 32'(cyc + 1 - e.t_in), 32'(L));
          end
        end
      end
    end
  end

  initial begin : main
    int n = 0;
    while (n_done < 3 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n_done < 3) note_fail(-1, "global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
